// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter
//  Shares one RAM port among the per-core instruction and data requesters.
//  Data requests take priority. Each class is served round-robin.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic                     busy
);

  localparam int c_CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  localparam logic [1:0] c_FREE   = 2'd0;
  localparam logic [1:0] c_BUSY   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_gcore, w_gcore_nxt;
  logic [c_CW-1:0]   r_dptr,  w_dptr_nxt;
  logic [c_CW-1:0]   r_iptr,  w_iptr_nxt;

  logic [CPUS-1:0]   w_dreq;
  logic              w_dfound, w_ifound;
  logic [c_CW-1:0]   w_dsel,   w_isel;

  logic [WORD_W-1:0] w_iaddr  [CPUS];
  logic [WORD_W-1:0] w_daddr  [CPUS];
  logic [WORD_W-1:0] w_dstore [CPUS];

  genvar k;
  generate
    for (k = 0; k < CPUS; k++) begin : g_core
      assign w_iaddr[k]  = iaddr[k*WORD_W +: WORD_W];
      assign w_daddr[k]  = daddr[k*WORD_W +: WORD_W];
      assign w_dstore[k] = dstore[k*WORD_W +: WORD_W];
      assign iload[k*WORD_W +: WORD_W] = ramload;
      assign dload[k*WORD_W +: WORD_W] = ramload;
    end
  endgenerate

  // Descending scan so the nearest candidate after the pointer is written last.
  always_comb begin
    w_dreq   = dREN | dWEN;
    w_dfound = 1'b0;
    w_dsel   = '0;
    w_ifound = 1'b0;
    w_isel   = '0;
    for (int i = CPUS; i >= 1; i--) begin
      int di;
      int ii;
      di = (int'(r_dptr) + i) % CPUS;
      ii = (int'(r_iptr) + i) % CPUS;
      if (w_dreq[di]) begin
        w_dfound = 1'b1;
        w_dsel   = di[c_CW-1:0];
      end
      if (iREN[ii]) begin
        w_ifound = 1'b1;
        w_isel   = ii[c_CW-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_gcore <= '0;
      r_dptr  <= c_CW'(CPUS-1);
      r_iptr  <= c_CW'(CPUS-1);
    end else begin
      r_state <= w_state_nxt;
      r_gcore <= w_gcore_nxt;
      r_dptr  <= w_dptr_nxt;
      r_iptr  <= w_iptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gcore_nxt = r_gcore;
    w_dptr_nxt  = r_dptr;
    w_iptr_nxt  = r_iptr;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = '1;
    dwait       = '1;
    busy        = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_dfound) begin
          w_state_nxt = DGRANT;
          w_gcore_nxt = w_dsel;
        end else if (w_ifound) begin
          w_state_nxt = IGRANT;
          w_gcore_nxt = w_isel;
        end
      end

      DGRANT: begin
        ramaddr = w_daddr[r_gcore];
        if (dWEN[r_gcore]) begin
          ramWEN   = 1'b1;
          ramstore = w_dstore[r_gcore];
        end else begin
          ramREN = 1'b1;
        end
        case (ramstate)
          c_ACCESS: begin
            dwait[r_gcore] = 1'b0;
            w_state_nxt    = IDLE;
            w_dptr_nxt     = r_gcore;
          end
          // Pointer untouched so the same requester is retried first.
          c_ERROR:  w_state_nxt = IDLE;
          c_FREE, c_BUSY: ;
          default: ;
        endcase
      end

      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = w_iaddr[r_gcore];
        case (ramstate)
          c_ACCESS: begin
            iwait[r_gcore] = 1'b0;
            w_state_nxt    = IDLE;
            w_iptr_nxt     = r_gcore;
          end
          c_ERROR:  w_state_nxt = IDLE;
          c_FREE, c_BUSY: ;
          default: ;
        endcase
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter
//  Directed self-checking bench for mem_arbiter with CPUS=2, WORD_W=32.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int CPUS   = 2;
  localparam int WORD_W = 32;

  localparam logic [1:0] c_FREE   = 2'd0;
  localparam logic [1:0] c_BUSY   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ERROR  = 2'd3;

  logic                   CLK;
  logic                   nRST;
  logic [CPUS-1:0]        iREN;
  logic [CPUS*WORD_W-1:0] iaddr;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*WORD_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   busy;

  int n_total = 0;
  int n_bad   = 0;

  mem_arbiter #(.CPUS(CPUS), .WORD_W(WORD_W)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    nRST     = 1'b0;
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    iaddr    = '0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = c_FREE;
    #1;
    check("rst_busy",  busy,    1'b0);
    check("rst_iwait", iwait,   2'b11);
    check("rst_dwait", dwait,   2'b11);
    check("rst_ren",   ramREN,  1'b0);
    check("rst_wen",   ramWEN,  1'b0);
    check("rst_addr",  ramaddr, 32'h0);
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;

    // Single fetch: two BUSY cycles, then ACCESS.
    step();
    iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = c_BUSY;
    settle();
    check("f_idle_ren", ramREN, 1'b0);
    step(); settle();
    check("f_g_ren",   ramREN,  1'b1);
    check("f_g_addr",  ramaddr, 32'h40);
    check("f_g_busy",  busy,    1'b1);
    check("f_g_iwait", iwait,   2'b11);
    step(); settle();
    check("f_hold_ren",   ramREN, 1'b1);
    check("f_hold_iwait", iwait,  2'b11);
    step();
    ramstate = c_ACCESS; ramload = 32'hDEADBEEF;
    settle();
    check("f_done_iwait", iwait, 2'b10);
    check("f_done_dwait", dwait, 2'b11);
    check("f_iload",      iload, 64'hDEADBEEF_DEADBEEF);
    check("f_dload",      dload, 64'hDEADBEEF_DEADBEEF);
    step();
    iREN = '0; ramstate = c_FREE;
    settle();
    check("f_after_busy",  busy,  1'b0);
    check("f_after_iwait", iwait, 2'b11);

    // Data priority: core 1 store beats core 0 fetch.
    iREN = 2'b01; iaddr[31:0] = 32'h44;
    dWEN = 2'b10; daddr[63:32] = 32'h80; dstore[63:32] = 32'h1234;
    ramstate = c_BUSY;
    step(); settle();
    check("p_d_wen",   ramWEN,   1'b1);
    check("p_d_ren",   ramREN,   1'b0);
    check("p_d_addr",  ramaddr,  32'h80);
    check("p_d_store", ramstore, 32'h1234);
    ramstate = c_ACCESS;
    settle();
    check("p_d_dwait", dwait, 2'b01);
    check("p_d_iwait", iwait, 2'b11);
    step();
    dWEN = '0; ramstate = c_BUSY;
    settle();
    check("p_bubble", busy, 1'b0);
    step(); settle();
    check("p_i_ren",  ramREN,  1'b1);
    check("p_i_wen",  ramWEN,  1'b0);
    check("p_i_addr", ramaddr, 32'h44);
    ramstate = c_ACCESS;
    settle();
    check("p_i_iwait", iwait, 2'b10);
    step();
    iREN = '0;

    // Round-robin: both data cores read continuously, ACCESS every cycle.
    dREN = 2'b11; daddr[31:0] = 32'h100; daddr[63:32] = 32'h200;
    for (int g = 0; g < 4; g++) begin
      step(); settle();
      check("rr_addr",  ramaddr, (g % 2 == 0) ? 32'h100 : 32'h200);
      check("rr_dwait", dwait,   (g % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_ren",   ramREN,  1'b1);
      step(); settle();
      check("rr_bubble", busy, 1'b0);
    end
    dREN = '0; ramstate = c_BUSY;

    // Write precedence, then asynchronous reset during the grant.
    dREN = 2'b01; dWEN = 2'b01; daddr[31:0] = 32'h300; dstore[31:0] = 32'hCAFE;
    step(); settle();
    check("w_wen",   ramWEN,   1'b1);
    check("w_ren",   ramREN,   1'b0);
    check("w_store", ramstore, 32'hCAFE);
    nRST = 1'b0;
    settle();
    check("ar_wen",   ramWEN, 1'b0);
    check("ar_ren",   ramREN, 1'b0);
    check("ar_busy",  busy,   1'b0);
    check("ar_dwait", dwait,  2'b11);
    step();
    nRST = 1'b1;
    step(); settle();
    check("ar_regrant_wen",  ramWEN,  1'b1);
    check("ar_regrant_addr", ramaddr, 32'h300);
    ramstate = c_ACCESS;
    settle();
    check("ar_done_dwait", dwait, 2'b10);
    step();
    dREN = '0; dWEN = '0; ramstate = c_BUSY;

    // Error retry: core 1 errors once, retried ahead of pending core 0.
    dREN = 2'b11;
    step(); settle();
    check("e_g1_addr", ramaddr, 32'h200);
    ramstate = c_ERROR;
    settle();
    check("e_err_dwait", dwait, 2'b11);
    step();
    ramstate = c_BUSY;
    settle();
    check("e_idle_busy",  busy,  1'b0);
    check("e_idle_dwait", dwait, 2'b11);
    step(); settle();
    check("e_retry_addr", ramaddr, 32'h200);
    ramstate = c_ACCESS;
    settle();
    check("e_retry_dwait", dwait, 2'b01);
    step();
    dREN = 2'b01; ramstate = c_BUSY;
    settle();
    check("e_bubble_dwait", dwait, 2'b11);
    step(); settle();
    check("e_g0_addr",  ramaddr, 32'h300);
    check("e_g0_dwait", dwait,   2'b11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shared-memory sequencer between the per-core instruction and data caches and the single RAM port.
- Accepts instruction-fetch, data-load and data-store requests from CPUS cores and grants one at a time.
- Drives the RAM port, returns load data, and generates per-requester wait handshakes.
- Sits between the caches' memory-side bus and RAM.

Parameters:
- CPUS, 2, number of cores; each core has one instruction requester and one data requester.
- WORD_W, 32, address/data word width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  per-core instruction read request.
- iaddr  in  CPUS*WORD_W  per-core instruction address (core k at [k*WORD_W +: WORD_W]).
- dREN  in  CPUS  per-core data read request.
- dWEN  in  CPUS  per-core data write request.
- daddr  in  CPUS*WORD_W  per-core data address.
- dstore  in  CPUS*WORD_W  per-core store data.
- iwait  out  CPUS  per-core instruction wait; low for exactly the completing cycle.
- dwait  out  CPUS  per-core data wait; low for exactly the completing cycle.
- iload  out  CPUS*WORD_W  ramload replicated to every core.
- dload  out  CPUS*WORD_W  ramload replicated to every core.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- busy  out  1  high when state != IDLE.

Behaviour:
- State register: {state, gcore}. state is IDLE, DGRANT or IGRANT; gcore is the granted core index. Pointers dptr and iptr hold the last-served data core and instruction core.
- Reset (async, nRST=0): state=IDLE, gcore=0, dptr=CPUS-1, iptr=CPUS-1.
- Outputs during reset and IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait=1, all dwait=1, busy=0.
- Reset mid-transaction: abort immediately with no completion pulse. Requesters keep their requests and are re-arbitrated after release.
- IDLE arbitration, registered, on each clock:
  - A data request is any dREN[k]|dWEN[k]. Any data request wins over every instruction request.
  - Among data requests, pick the first k searching dptr+1, dptr+2, … modulo CPUS. Go to DGRANT with gcore=k.
  - Otherwise, among iREN, search the same way from iptr+1. Go to IGRANT.
  - No request: stay in IDLE.
- DGRANT:
  - ramaddr = daddr[gcore].
  - If dWEN[gcore]=1: ramWEN=1, ramstore=dstore[gcore], ramREN=0. A write takes precedence when dREN and dWEN are both high.
  - Otherwise ramREN=1.
- IGRANT: ramREN=1, ramaddr=iaddr[gcore].
- Completion, combinational, when ramstate==ACCESS in a grant state:
  - The granted wait bit (dwait[gcore] or iwait[gcore]) goes 0 in that same cycle; every other wait stays 1.
  - Next state is IDLE. dptr (or iptr) is updated to gcore.
  - Minimum latency: request seen → 1 cycle to grant → RAM cycles → 1 bubble in IDLE before the next grant.
- ramstate FREE or BUSY in a grant state: hold state and RAM outputs; waits stay 1.
- ramstate ERROR in a grant state:
  - No completion pulse. Return to IDLE and re-arbitrate. The pointer is not updated, so the same requester retries first.
- Granted request drops before completion (protocol violation): still finish on ACCESS. The wait pulse is emitted regardless and the RAM write, if any, has occurred.
- Requester addresses and store data must be stable while the request is high; the arbiter does not latch them.
- Fairness:
  - Round-robin within each class guarantees no core waits more than CPUS-1 same-class grants.
  - Instruction starvation under continuous data traffic is permitted by design.

Test Plan:
- Reset: nRST=0 mid-DGRANT with ramstate=BUSY → ramWEN=0, ramREN=0, all waits=1, busy=0 asynchronously; after release, the same request is re-granted next clock.
- Single fetch: iREN[0]=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramREN=1, ramaddr=0x40 from cycle 1; iwait[0]=0 for one cycle with iload[0]=0xDEADBEEF.
- Data priority: iREN[0]=1 and dWEN[1]=1, daddr=0x80, dstore=0x1234 in the same cycle → DGRANT core 1 (ramWEN=1, ramaddr=0x80, ramstore=0x1234) first, then IGRANT core 0.
- Round-robin: dREN[0] and dREN[1] held continuously, ACCESS on every grant cycle → grants alternate 0,1,0,1; dwait pulses alternate.
- Write precedence: dREN[0]=dWEN[0]=1 → ramWEN=1, ramREN=0.
- Error retry: ERROR returned on the first attempt for core 1, then ACCESS → core 1 is re-granted before core 0's pending data request; exactly one dwait[1] low pulse.
